// File: rtl/vec_sub_sched.sv
// vec_sub_sched: one element-wise vector subtractor shared by two requesters.
//
// Arbitration is round-robin. R0 and R1 present (a, b) vector pairs. The
// granted pair is subtracted lane by lane, a - b. Each lane is either
// saturated to the signed FXP_N range or wrapped. The result is loaded into
// a one-entry registered output slot that uses a valid/ready handshake.
//
// Ports
//   clock, reset_n          : rising-edge clock, asynchronous active-low reset
//   r{0,1}_valid / _ready   : request handshake. ready is combinational.
//   r{0,1}_a / _b           : ARR_WIDTH lanes of signed FXP_N operands
//   out_valid / out_ready   : result slot handshake
//   out_data                : per-lane a - b (saturated or wrapped)
//   out_id                  : requester of the held result (0 = R0, 1 = R1)
//   out_sat                 : per-lane clamp flags (always 0 when SATURATE=0)
//   sat_cnt_clr             : synchronous clear of sat_cnt. It wins over increment.
//   sat_cnt                 : number of accepted results with any clamped lane.
//                             The count saturates at all-ones.
`ifndef ARR_WIDTH
`define ARR_WIDTH 4
`endif
`ifndef FXP_N
`define FXP_N 16
`endif

module vec_sub_sched #(
    parameter int SATURATE = 1,
    parameter int CNT_W    = 16
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              r0_valid,
    output logic                              r0_ready,
    input  logic [`ARR_WIDTH-1:0][`FXP_N-1:0] r0_a,
    input  logic [`ARR_WIDTH-1:0][`FXP_N-1:0] r0_b,
    input  logic                              r1_valid,
    output logic                              r1_ready,
    input  logic [`ARR_WIDTH-1:0][`FXP_N-1:0] r1_a,
    input  logic [`ARR_WIDTH-1:0][`FXP_N-1:0] r1_b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [`ARR_WIDTH-1:0][`FXP_N-1:0] out_data,
    output logic                              out_id,
    output logic [`ARR_WIDTH-1:0]             out_sat,
    input  logic                              sat_cnt_clr,
    output logic [CNT_W-1:0]                  sat_cnt
);

    localparam int AW = `ARR_WIDTH;
    localparam int FW = `FXP_N;

    // When both requesters are valid, ptr_q selects the winner: 0 = R0, 1 = R1.
    logic                   ptr_q, ptr_d;
    logic                   out_valid_q, out_valid_d;
    logic [AW-1:0][FW-1:0]  out_data_q, out_data_d;
    logic                   out_id_q, out_id_d;
    logic [AW-1:0]          out_sat_q, out_sat_d;
    logic [CNT_W-1:0]       sat_cnt_q, sat_cnt_d;

    logic                   slot_free_s;
    logic                   gnt0_s, gnt1_s, accept_s;
    logic [AW-1:0][FW-1:0]  a_sel_s, b_sel_s, diff_s;
    logic [AW-1:0]          clamp_s;

    // Return {clamp, result} for one lane. The difference is formed at FW+1
    // bits. When its top two bits disagree, the difference is outside the
    // FW-bit signed range.
    function automatic logic [FW:0] sub_lane(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW:0] d;
        logic [FW:0] res;
        d = {a[FW-1], a} - {b[FW-1], b};
        if ((SATURATE != 0) && (d[FW] != d[FW-1])) begin
            // Positive overflow gives 0111..1. Negative overflow gives 1000..0.
            res = {1'b1, d[FW], {(FW-1){~d[FW]}}};
        end else begin
            res = {1'b0, d[FW-1:0]};
        end
        return res;
    endfunction

    // Round-robin grant. Reset and a stalled slot both suppress every grant.
    always_comb begin
        slot_free_s = ~out_valid_q | out_ready;
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        if (reset_n && slot_free_s) begin
            if (r0_valid && r1_valid) begin
                gnt0_s = ~ptr_q;
                gnt1_s = ptr_q;
            end else begin
                gnt0_s = r0_valid;
                gnt1_s = r1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
        accept_s = gnt0_s | gnt1_s;
    end

    // Operand mux and per-lane subtract with optional clamp.
    always_comb begin
        a_sel_s = gnt1_s ? r1_a : r0_a;
        b_sel_s = gnt1_s ? r1_b : r0_b;
        diff_s  = '0;
        clamp_s = '0;
        for (int i = 0; i < AW; i++) begin
            {clamp_s[i], diff_s[i]} = sub_lane(a_sel_s[i], b_sel_s[i]);
        end
    end

    // Next state for the output slot, the pointer and the saturation counter.
    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_sat_d   = out_sat_q;
        sat_cnt_d   = sat_cnt_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            out_data_d  = diff_s;
            out_id_d    = gnt1_s;
            out_sat_d   = clamp_s;
            // The next tie goes to the requester that was not just served.
            ptr_d       = gnt0_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (sat_cnt_clr) begin
            sat_cnt_d = '0;
        end else if (accept_s && (|clamp_s) && (sat_cnt_q != {CNT_W{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            out_sat_q   <= '0;
            sat_cnt_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_sat_q   <= out_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign r0_ready  = gnt0_s;
    assign r1_ready  = gnt1_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_vec_sub_sched.sv
// Testbench for vec_sub_sched. It drives two instances with identical
// stimulus: one saturating, one wrapping, both with a 4-bit counter.
// Both are compared against a behavioural model built from the arbitration
// and arithmetic rules.
`ifndef ARR_WIDTH
`define ARR_WIDTH 4
`endif
`ifndef FXP_N
`define FXP_N 16
`endif

module tb_vec_sub_sched;

    localparam int AW   = `ARR_WIDTH;
    localparam int FW   = `FXP_N;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int VMAX = (1 << (FW - 1)) - 1;
    localparam int VMIN = -(1 << (FW - 1));

    logic clock;
    logic reset_n;
    logic r0_valid, r1_valid, out_ready, sat_cnt_clr;
    logic [AW-1:0][FW-1:0] r0_a, r0_b, r1_a, r1_b;

    logic s_r0_ready, s_r1_ready, s_out_valid, s_out_id;
    logic [AW-1:0][FW-1:0] s_out_data;
    logic [AW-1:0] s_out_sat;
    logic [CW-1:0] s_sat_cnt;
    logic w_r0_ready, w_r1_ready, w_out_valid, w_out_id;
    logic [AW-1:0][FW-1:0] w_out_data;
    logic [AW-1:0] w_out_sat;
    logic [CW-1:0] w_sat_cnt;

    vec_sub_sched #(.SATURATE(1), .CNT_W(CW)) u_sat (
        .clock(clock), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(s_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(s_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_id(s_out_id), .out_sat(s_out_sat),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(s_sat_cnt)
    );

    vec_sub_sched #(.SATURATE(0), .CNT_W(CW)) u_wrap (
        .clock(clock), .reset_n(reset_n),
        .r0_valid(r0_valid), .r0_ready(w_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(w_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_id(w_out_id), .out_sat(w_out_sat),
        .sat_cnt_clr(sat_cnt_clr), .sat_cnt(w_sat_cnt)
    );

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state.
    bit                    m_valid;
    bit                    m_id;
    bit                    m_pref;   // requester favoured on a tie
    logic [AW-1:0][FW-1:0] m_data_s, m_data_w;
    logic [AW-1:0]         m_sat_s;
    int                    m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] l0, input logic [15:0] l1);
        return {32'd0, l1, l0};
    endfunction

    // Plain-integer lane reference: subtract, then clamp or wrap.
    task automatic ref_lane(input int a, input int b, input bit satmode,
                            output logic [FW-1:0] r, output bit c);
        int d;
        d = a - b;
        c = 1'b0;
        if (satmode && d > VMAX) begin
            r = VMAX[FW-1:0]; c = 1'b1;
        end else if (satmode && d < VMIN) begin
            r = VMIN[FW-1:0]; c = 1'b1;
        end else begin
            r = d[FW-1:0];
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 1'b0;
        m_pref   = 1'b0;
        m_data_s = '0;
        m_data_w = '0;
        m_sat_s  = '0;
        m_cnt    = 0;
    endtask

    // One clock of stimulus, with checks before and after the edge.
    task automatic step(input bit v0, input bit v1, input bit rdy, input bit clr,
                        input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1);
        bit granted, who, c;
        logic [FW-1:0] r;
        logic [AW-1:0][FW-1:0] sa, sb, ds, dw;
        logic [AW-1:0] sv;
        @(negedge clock);
        r0_valid = v0; r1_valid = v1; out_ready = rdy; sat_cnt_clr = clr;
        r0_a = a0; r0_b = b0; r1_a = a1; r1_b = b1;
        #1;
        granted = 1'b0; who = 1'b0;
        if (!m_valid || rdy) begin
            if (v0 && v1) begin granted = 1'b1; who = m_pref; end
            else if (v0)  begin granted = 1'b1; who = 1'b0; end
            else if (v1)  begin granted = 1'b1; who = 1'b1; end
        end
        chk("s_r0_ready", s_r0_ready, granted && !who);
        chk("s_r1_ready", s_r1_ready, granted && who);
        chk("w_r0_ready", w_r0_ready, granted && !who);
        chk("w_r1_ready", w_r1_ready, granted && who);
        sa = who ? a1 : a0;
        sb = who ? b1 : b0;
        for (int i = 0; i < AW; i++) begin
            ref_lane($signed(sa[i]), $signed(sb[i]), 1'b1, r, c);
            ds[i] = r; sv[i] = c;
            ref_lane($signed(sa[i]), $signed(sb[i]), 1'b0, r, c);
            dw[i] = r;
        end
        @(posedge clock);
        #1;
        if (granted) begin
            m_valid = 1'b1; m_id = who; m_data_s = ds; m_data_w = dw; m_sat_s = sv;
            m_pref = !who;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        if (clr) m_cnt = 0;
        else if (granted && (sv != 0) && m_cnt < CMAX) m_cnt++;
        chk("s_out_valid", s_out_valid, m_valid);
        chk("w_out_valid", w_out_valid, m_valid);
        chk("s_sat_cnt", s_sat_cnt, m_cnt);
        chk("w_sat_cnt", w_sat_cnt, 0);
        if (m_valid) begin
            chk("s_out_data", s_out_data, m_data_s);
            chk("w_out_data", w_out_data, m_data_w);
            chk("s_out_id", s_out_id, m_id);
            chk("w_out_id", w_out_id, m_id);
            chk("s_out_sat", s_out_sat, m_sat_s);
            chk("w_out_sat", w_out_sat, 0);
        end
    endtask

    function automatic logic [FW-1:0] rnd_lane();
        case ($urandom_range(0, 5))
            0: return {1'b0, {(FW-1){1'b1}}};
            1: return {1'b1, {(FW-1){1'b0}}};
            2: return {FW{1'b1}};
            default: return FW'($urandom);
        endcase
    endfunction

    function automatic logic [63:0] rnd_vec();
        logic [AW-1:0][FW-1:0] v;
        for (int i = 0; i < AW; i++) v[i] = rnd_lane();
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_valid"}, s_out_valid, 0);
        chk({tag, "_s_data"},  s_out_data, 0);
        chk({tag, "_s_id"},    s_out_id, 0);
        chk({tag, "_s_sat"},   s_out_sat, 0);
        chk({tag, "_s_cnt"},   s_sat_cnt, 0);
        chk({tag, "_w_valid"}, w_out_valid, 0);
        chk({tag, "_s_r0rdy"}, s_r0_ready, 0);
        chk({tag, "_s_r1rdy"}, s_r1_ready, 0);
        chk({tag, "_w_r0rdy"}, w_r0_ready, 0);
    endtask

    logic [63:0] pa, pb;

    initial begin
        reset_n = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1; out_ready = 1'b1; sat_cnt_clr = 1'b0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        r0_valid = 1'b0; r1_valid = 1'b0;
        #4 reset_n = 1'b1;

        // Single R0 request.
        step(1, 0, 1, 0, mk(16'd100, 16'd0), mk(16'd30, 16'd0), '0, '0);
        chk("t1_lane0", s_out_data[0], 16'd70);
        chk("t1_id", s_out_id, 0);

        // Alternating grants, then R0 alone.
        for (int i = 0; i < 6; i++) step(1, 1, 1, 0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());

        // Saturation at both ends, one count per result.
        step(0, 0, 1, 1, '0, '0, '0, '0);
        step(1, 0, 1, 0, mk(16'h7fff, 16'd0), mk(16'hffff, 16'd0), '0, '0);
        chk("t3_max", s_out_data[0], 16'h7fff);
        chk("t3_wrap_max", w_out_data[0], 16'h8000);
        chk("t3_cnt1", s_sat_cnt, 1);
        step(1, 0, 1, 0, mk(16'd0, 16'h8000), mk(16'd0, 16'd1), '0, '0);
        chk("t3_min", s_out_data[1], 16'h8000);
        chk("t3_wrap_min", w_out_data[1], 16'h7fff);
        chk("t3_cnt2", s_sat_cnt, 2);

        // Stall with both valid, then drain and reload in the same cycle.
        pa = rnd_vec(); pb = rnd_vec();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, pa, pb, pb, pa);
        step(1, 1, 1, 0, pa, pb, pb, pa);

        // Asynchronous reset in the middle of a stall.
        step(1, 1, 0, 0, pa, pb, pb, pa);
        step(1, 1, 0, 0, pa, pb, pb, pa);
        #2 reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        r0_valid = 1'b0; r1_valid = 1'b0;
        #3 reset_n = 1'b1;
        step(0, 1, 1, 0, pa, pb, pb, pa);
        chk("t5_r1_id", s_out_id, 1);
        step(1, 1, 1, 0, pa, pb, pb, pa);
        step(1, 1, 1, 0, pa, pb, pb, pa);

        // The counter saturates, then a clear wins over a saturating accept.
        for (int i = 0; i < CMAX + 3; i++)
            step(1, 0, 1, 0, mk(16'h7fff, 16'd0), mk(16'h8000, 16'd0), '0, '0);
        chk("t6_cnt_max", s_sat_cnt, CMAX);
        step(1, 0, 1, 1, mk(16'h7fff, 16'd0), mk(16'h8000, 16'd0), '0, '0);
        chk("t6_cnt_clr", s_sat_cnt, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
